// File: rtl/swap_sched_ctrl.sv
// Two-requester swap scheduler: round-robin arbitration of swap requests
// over a small register bank, with a fixed LOAD/WRITE/DONE sequence, a
// direct load port and a combinational read port.
module swap_sched_ctrl #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_idx_a,
  input  logic [AW-1:0] req0_idx_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_idx_a,
  input  logic [AW-1:0] req1_idx_b,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [N-1:0]  rd_data,
  output logic          busy,
  output logic          done,
  output logic          done_id,
  output logic [7:0]    swap_count
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  // Bit k set when index k addresses a real bank register.
  function automatic logic [2**AW-1:0] mk_idx_ok();
    logic [2**AW-1:0] m;
    for (int k = 0; k < 2**AW; k++) m[k] = (k < DEPTH);
    return m;
  endfunction

  localparam logic [2**AW-1:0] IDX_OK = mk_idx_ok();

  state_t        state;
  logic [N-1:0]  bank [DEPTH];
  logic [N-1:0]  tmp_a, tmp_b;
  logic [AW-1:0] idx_a, idx_b;
  logic          owner;
  logic          prio;     // 0: requester 0 holds priority, 1: requester 1
  logic          gnt0, gnt1;

  // Round-robin grant, only in IDLE with no direct load pending.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && state == IDLE && !wr_en) begin
      if (req0_valid && (!req1_valid || !prio)) gnt0 = 1'b1;
      else if (req1_valid)                      gnt1 = 1'b1;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign busy       = (state != IDLE);

  // Combinational read port; out-of-range indices read as zero.
  always_comb begin
    rd_data = '0;
    if (IDX_OK[rd_idx]) rd_data = bank[rd_idx];
  end

  // Swap operands captured at grant and at LOAD; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && (gnt0 || gnt1)) begin
      idx_a <= gnt1 ? req1_idx_a : req0_idx_a;
      idx_b <= gnt1 ? req1_idx_b : req0_idx_b;
    end
    if (state == LOAD) begin
      tmp_a <= IDX_OK[idx_a] ? bank[idx_a] : '0;
      tmp_b <= IDX_OK[idx_b] ? bank[idx_b] : '0;
    end
  end

  // Sequencer FSM: owns state, priority pointer, bank writes and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      done       <= 1'b0;
      done_id    <= 1'b0;
      swap_count <= '0;
      for (int k = 0; k < DEPTH; k++) bank[k] <= '0;
    end else begin
      done    <= 1'b0;
      done_id <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en) begin
            if (IDX_OK[wr_idx]) bank[wr_idx] <= wr_data;
          end else if (gnt0 || gnt1) begin
            owner <= gnt1;
            prio  <= gnt0;
            state <= LOAD;
          end
        end
        LOAD: state <= WRITE;
        WRITE: begin
          if (IDX_OK[idx_a]) bank[idx_a] <= tmp_b;
          if (IDX_OK[idx_b]) bank[idx_b] <= tmp_a;
          done       <= 1'b1;
          done_id    <= owner;
          swap_count <= swap_count + 8'd1;
          state      <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swap_sched_ctrl.sv
// Self-checking bench for swap_sched_ctrl: a transaction-level model of the
// bank and arbitration is compared against the DUT every cycle, and directed
// scenarios add hand-computed expectations.
`timescale 1ns/1ps
module tb_swap_sched_ctrl;
  localparam int N = 8, DEPTH = 4, AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [AW-1:0] req0_idx_a, req0_idx_b, req1_idx_a, req1_idx_b;
  logic          wr_en;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [N-1:0]  wr_data, rd_data;
  logic          busy, done, done_id;
  logic [7:0]    swap_count;

  swap_sched_ctrl #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_idx_a(req0_idx_a), .req0_idx_b(req0_idx_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_idx_a(req1_idx_a), .req1_idx_b(req1_idx_b),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .busy(busy), .done(done), .done_id(done_id), .swap_count(swap_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // age: 0 = free, 1..3 = cycles since the accepting edge (3 = completion cycle)
  logic [N-1:0]  mbank [DEPTH];
  int            age = 0;
  logic          m_owner = 1'b0, m_prio = 1'b0;
  logic [AW-1:0] m_a = '0, m_b = '0;
  logic [7:0]    m_count = '0;

  // Which requester the scheduler must accept now: bit0 = req0, bit1 = req1.
  function automatic logic [1:0] pick();
    logic [1:0] g;
    g = 2'b00;
    if (!reset && age == 0 && !wr_en) begin
      if (req0_valid && req1_valid) g = m_prio ? 2'b10 : 2'b01;
      else if (req0_valid)          g = 2'b01;
      else if (req1_valid)          g = 2'b10;
    end
    return g;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic [1:0]   g;
    logic [N-1:0] t;
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) mbank[k] = '0;
      age = 0; m_prio = 1'b0; m_owner = 1'b0; m_count = '0;
    end else begin
      g = pick();
      if (age == 0) begin
        if (wr_en) mbank[wr_idx] = wr_data;
        else if (g != 2'b00) begin
          age     = 1;
          m_owner = g[1];
          m_a     = g[1] ? req1_idx_a : req0_idx_a;
          m_b     = g[1] ? req1_idx_b : req0_idx_b;
          m_prio  = g[0];
        end
      end else if (age == 2) begin
        t = mbank[m_a]; mbank[m_a] = mbank[m_b]; mbank[m_b] = t;
        m_count = m_count + 8'd1;
        age = 3;
      end else if (age == 3) age = 0;
      else age = age + 1;
    end
  end

  // ---------------- per-cycle comparison ----------------
  int   gnt_log[$];
  int   done_log[$];
  logic in_t3 = 1'b0;
  logic seen_busy_t3 = 1'b0;
  int   idle_run = 0;
  int   max_gap_t3 = 0;

  always @(negedge clk) begin : compare
    logic [1:0] g;
    if (!reset) begin
      g = pick();
      check("req0_ready", req0_ready, g[0]);
      check("req1_ready", req1_ready, g[1]);
      check("busy", busy, age != 0);
      check("done", done, age == 3);
      check("done_id", done_id, (age == 3) && m_owner);
      check("swap_count", swap_count, m_count);
      check("rd_data", rd_data, mbank[rd_idx]);
      if (req0_valid && req0_ready) gnt_log.push_back(0);
      if (req1_valid && req1_ready) gnt_log.push_back(1);
      if (done) done_log.push_back(int'(done_id));
      if (busy) begin
        if (in_t3 && seen_busy_t3 && idle_run > max_gap_t3) max_gap_t3 = idle_run;
        if (in_t3) seen_busy_t3 = 1'b1;
        idle_run = 0;
      end else idle_run++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [AW-1:0] a, input logic [AW-1:0] b);
    if (r == 0) begin req0_valid = v; req0_idx_a = a; req0_idx_b = b; end
    else        begin req1_valid = v; req1_idx_a = a; req1_idx_b = b; end
  endtask

  // Hold a request valid until it has been accepted n times, then drop it.
  task automatic run_reqs(input int r, input logic [AW-1:0] a, input logic [AW-1:0] b, input int n);
    int got;
    got = 0;
    set_req(r, 1'b1, a, b);
    for (int i = 0; i < n * 8 + 8 && got < n; i++) begin
      @(negedge clk);
      if ((r == 0) ? req0_ready : req1_ready) got++;
      @(posedge clk); #1;
    end
    set_req(r, 1'b0, a, b);
    check($sformatf("accepted_req%0d", r), got, n);
  endtask

  task automatic load(input logic [AW-1:0] idx, input logic [N-1:0] d);
    wr_en = 1'b1; wr_idx = idx; wr_data = d;
    cycles(1);
    wr_en = 1'b0;
  endtask

  task automatic peek(input logic [AW-1:0] idx, input logic [N-1:0] exp);
    @(posedge clk); #1;
    rd_idx = idx;
    #1;
    check($sformatf("bank[%0d]", idx), rd_data, exp);
  endtask

  task automatic peek4(input logic [N-1:0] e0, input logic [N-1:0] e1,
                       input logic [N-1:0] e2, input logic [N-1:0] e3);
    peek(0, e0); peek(1, e1); peek(2, e2); peek(3, e3);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : main
    int base;
    reset = 1'b1;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0; rd_idx = '0;
    set_req(0, 1'b1, 0, 0);
    set_req(1, 1'b0, 0, 0);
    #3;
    check("reset_ready0", req0_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_done_id", done_id, 0);
    check("reset_count", swap_count, 0);
    check("reset_rd", rd_data, 0);
    set_req(0, 1'b0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Test 1: single swap(0,3) by requester 0
    load(0, 8'h11); load(1, 8'h22); load(2, 8'h33); load(3, 8'h44);
    set_req(0, 1'b1, 0, 3);
    @(negedge clk);
    check("t1_ready0", req0_ready, 1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_done_id", done_id, 0);
    check("t1_count", swap_count, 1);
    peek4(8'h44, 8'h22, 8'h33, 8'h11);

    // Test 2: both request swap(1,2); pointer favours requester 1 after test 1
    base = done_log.size();
    fork
      run_reqs(0, 1, 2, 1);
      run_reqs(1, 1, 2, 1);
    join
    cycles(4);
    check("t2_done_cnt", done_log.size(), base + 2);
    if (done_log.size() == base + 2) begin
      check("t2_first_id", done_log[base], 1);
      check("t2_second_id", done_log[base+1], 0);
    end
    check("t2_count", swap_count, 3);
    peek4(8'h44, 8'h22, 8'h33, 8'h11);

    // Test 3: continuous contention, six grants
    base = gnt_log.size();
    in_t3 = 1'b1;
    fork
      run_reqs(0, 0, 1, 3);
      run_reqs(1, 2, 3, 3);
    join
    cycles(4);
    in_t3 = 1'b0;
    check("t3_grant_cnt", gnt_log.size(), base + 6);
    if (gnt_log.size() == base + 6)
      for (int i = 0; i < 6; i++) check($sformatf("t3_grant%0d", i), gnt_log[base+i], (i % 2 == 0) ? 1 : 0);
    check("t3_max_idle_gap", max_gap_t3, 1);
    check("t3_count", swap_count, 9);
    peek4(8'h22, 8'h44, 8'h11, 8'h33);

    // Test 4: load beats a pending request; load while busy is dropped
    set_req(1, 1'b1, 0, 1);
    wr_en = 1'b1; wr_idx = 2; wr_data = 8'hAA;
    @(negedge clk);
    check("t4_ready1_blocked", req1_ready, 0);
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("t4_ready1_next", req1_ready, 1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 0, 0);
    wr_en = 1'b1; wr_idx = 3; wr_data = 8'h55;
    cycles(3);
    wr_en = 1'b0;
    check("t4_count", swap_count, 10);
    peek4(8'h44, 8'h22, 8'hAA, 8'h33);

    // Test 5: degenerate swap(2,2) by requester 1
    base = done_log.size();
    run_reqs(1, 2, 2, 1);
    cycles(4);
    check("t5_done_cnt", done_log.size(), base + 1);
    if (done_log.size() == base + 1) check("t5_done_id", done_log[base], 1);
    check("t5_count", swap_count, 11);
    peek4(8'h44, 8'h22, 8'hAA, 8'h33);

    // Test 6a: reset asserted during WRITE
    base = done_log.size();
    run_reqs(0, 0, 1, 1);
    @(posedge clk); #2;
    set_req(1, 1'b1, 2, 3);
    rd_idx = 0;
    reset = 1'b1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_count", swap_count, 0);
    check("t6_ready1", req1_ready, 0);
    check("t6_rd", rd_data, 0);
    @(posedge clk); #1;
    set_req(1, 1'b0, 0, 0);
    reset = 1'b0;
    cycles(4);
    check("t6_no_done", done_log.size(), base);
    peek4(8'h00, 8'h00, 8'h00, 8'h00);

    // Test 6b: swap_count wraps 255 -> 0
    run_reqs(0, 0, 1, 255);
    cycles(4);
    check("t6_count_255", swap_count, 255);
    run_reqs(0, 2, 3, 1);
    cycles(2);
    @(negedge clk);
    check("t6_wrap_done", done, 1);
    check("t6_wrap_count", swap_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
